cla_addsub_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's 4-bit CLA adder.
- Operand width is split into 4-bit CLA groups, one group per pipeline stage, with the group carry registered between stages.
- Valid/ready handshake on input and output, so it sits directly in the ALU datapath between the operand-select and result-writeback stages.
- Adds subtract mode, status flags and back-pressure, none of which the 4-bit adder has.

---
 rtl/cla_addsub_pipe.sv | 167 ++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_addsub_pipe
// Brief    : Pipelined carry-lookahead adder/subtractor, one 4-bit CLA group
//            per stage, valid/ready handshake with global stall, status flags
//            (cout, ovf, zero, neg).
//            Optional macro SATURATE_EN: clamp sum to the signed extreme on
//            overflow instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NGRP = WIDTH / 4;
  // Operand skew registers exist only between stages; keep at least one
  // element so the WIDTH=4 build stays legal.
  localparam int NOPS = (NGRP > 1) ? NGRP - 1 : 1;

  // 4-bit lookahead group: returns {c4, c3, sum[3:0]}. c3 is kept so the
  // last stage can form the signed-overflow flag.
  function automatic logic [5:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       c0);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, c3, p ^ {c3, c2, c1, c0}};
  endfunction

  // Pipeline state. r_s/r_c of the last stage are the registered outputs.
  logic [NGRP-1:0]  r_vld;
  logic [WIDTH-1:0] r_s [NGRP];
  logic [NGRP-1:0]  r_c;
  logic [WIDTH-1:0] r_a [NOPS];
  logic [WIDTH-1:0] r_b [NOPS];
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  // Per-stage inputs and results.
  logic [WIDTH-1:0] w_a_in  [NGRP];
  logic [WIDTH-1:0] w_b_in  [NGRP];
  logic [WIDTH-1:0] w_s_in  [NGRP];
  logic [WIDTH-1:0] w_s_nxt [NGRP];
  logic [NGRP-1:0]  w_c_in;
  logic [NGRP-1:0]  w_c_nxt;
  logic [NGRP-1:0]  w_c3;
  logic [WIDTH-1:0] w_fin;
  logic             w_cout;
  logic             w_ovf;
  logic             w_adv;

  // Global stall: everything moves unless a result is waiting and refused.
  assign w_adv     = out_ready | ~out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[NGRP-1];
  assign sum       = r_s[NGRP-1];
  assign cout      = r_c[NGRP-1];
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

  // Route stage inputs and evaluate each stage's CLA group. B is inverted
  // once at the entry; downstream stages see the already-selected B'.
  always_comb begin
    logic [5:0] res;
    res       = '0;
    w_a_in[0] = A;
    w_b_in[0] = sub ? ~B : B;
    w_c_in[0] = sub | cin;
    w_s_in[0] = '0;
    for (int k = 1; k < NGRP; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_c_in[k] = r_c[k-1];
      w_s_in[k] = r_s[k-1];
    end
    for (int k = 0; k < NGRP; k++) begin
      res                 = cla4(w_a_in[k][4*k +: 4], w_b_in[k][4*k +: 4], w_c_in[k]);
      w_s_nxt[k]          = w_s_in[k];
      w_s_nxt[k][4*k +: 4] = res[3:0];
      w_c_nxt[k]          = res[5];
      w_c3[k]             = res[4];
    end
  end

  // Final-stage flags and optional clamp; direction follows the sign of A.
  always_comb begin
    w_cout = w_c_nxt[NGRP-1];
    w_ovf  = w_c3[NGRP-1] ^ w_c_nxt[NGRP-1];
`ifdef SATURATE_EN
    if (w_ovf) begin
      w_fin = w_a_in[NGRP-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_fin = w_s_nxt[NGRP-1];
    end
`else
    w_fin = w_s_nxt[NGRP-1];
`endif
  end

  // Shift all stages together when advancing; hold everything otherwise.
  // Operand registers carry the full word; bits already consumed are never
  // read and drop out in synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      for (int k = 0; k < NGRP; k++) begin
        r_s[k] <= '0;
      end
      for (int k = 0; k < NOPS; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < NGRP; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      for (int k = 0; k < NGRP - 1; k++) begin
        r_s[k] <= w_s_nxt[k];
        r_c[k] <= w_c_nxt[k];
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
      end
      r_s[NGRP-1] <= w_fin;
      r_c[NGRP-1] <= w_cout;
      r_ovf       <= w_ovf;
      r_zero      <= (w_fin == '0);
      r_neg       <= w_fin[WIDTH-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_addsub_pipe
// Brief    : Scoreboard bench for cla_addsub_pipe (WIDTH=16); directed vectors,
//            back-pressure, and mid-flight reset. Honours SATURATE_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_cla_addsub_pipe;

  localparam int W    = 16;
  localparam int NGRP = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  cla_addsub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W+3:0] resp;   // {sum, cout, ovf, zero, neg}
    int           acc;
    bit           lat;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pushes = 0;
  int   pops   = 0;
  int   nid    = 0;
  bit   seen_valid;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: a beat leaves on every cycle with out_valid & out_ready.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got sum=%h, expected no beat", sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        chk($sformatf("beat%0d", e.id), {12'h0, sum, cout, ovf, zero, neg}, {12'h0, e.resp});
        if (e.lat) chk($sformatf("latency%0d", e.id), cyc - e.acc, NGRP);
      end
    end
  end

  // Present one beat, wait (bounded) for acceptance, record the expectation.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s,
                      input logic [W+3:0] resp, input bit lat);
    exp_t e;
    int   n;
    a_in = a; b_in = b; cin = c; sub = s; in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    e.resp = resp; e.acc = cyc; e.lat = lat; e.id = nid;
    nid++;
    pushes++;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    #3;
    chk("reset_outputs", {15'h0, out_valid, sum, cout, ovf, zero, neg}, 32'h0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("post_reset_valid", out_valid, 0);

    // Directed vectors, out_ready held high: full latency checks.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 4'b0000}, 1);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 4'b1010}, 1);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 4'b0001}, 1);
`ifdef SATURATE_EN
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h8000, 4'b1101}, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h7FFF, 4'b0100}, 1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h8000, 4'b1101}, 1);
`else
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 4'b1100}, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b0101}, 1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 4'b1110}, 1);
`endif
    send(16'h0010, 16'h0010, 1'b1, 1'b1, {16'h0000, 4'b1010}, 1);
    send(16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 4'b0000}, 1);
    drain();

    // Back-pressure: 8 beats streamed while out_ready drops for 6 cycles.
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          send(W'(i), 16'h0100, 1'b0, 1'b0, {W'(16'h0100 + i), 4'b0000}, 0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_head", {15'h0, out_valid, sum}, {15'h0, 1'b1, 16'h0101});
        repeat (3) @(posedge clk);
        #1;
        chk("stall_hold", {15'h0, out_valid, sum}, {15'h0, 1'b1, 16'h0101});
        out_ready = 1'b1;
      end
    join
    drain();
    chk("beat_count", pops, pushes);

    // Reset mid-flight: 3 beats in, head held at the output, then reset.
    send(16'h0001, 16'h0001, 1'b0, 1'b0, {16'h0002, 4'b0000}, 0);
    send(16'h0002, 16'h0002, 1'b0, 1'b0, {16'h0004, 4'b0000}, 0);
    send(16'h0003, 16'h0003, 1'b0, 1'b0, {16'h0006, 4'b0000}, 0);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {15'h0, out_valid, sum, cout, ovf, zero, neg}, 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("no_stale_beat", seen_valid, 0);
    @(posedge clk);
    #1;
    send(16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 4'b0000}, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
